mp_add_seq: RTL and testbench
=============================

# mp_add_seq

Multi-precision add/subtract sequencer that sits directly in front of and around the 32-bit ripple-carry adder (`RCA_32`). It accepts operands one 32-bit limb per transfer, least-significant limb first, drives the adder, and registers the limb sum. It also holds the inter-limb carry in a flop, so arbitrarily wide integers are added or subtracted at one limb per clock. Results stream out through a single-entry valid/ready output register.

## Interface
- `IDX_W`, default 8: width of the limb index counter; the index saturates at 2^IDX_W−1.
- `clk  in  1`: single clock, rising edge.
- `rst  in  1`: asynchronous, active-high reset.
- `in_valid  in  1`: an upstream limb is presented.
- `in_ready  out  1`: the block accepts a limb this cycle.
- `in_a  in  32`: operand A limb.
- `in_b  in  32`: operand B limb.
- `in_sub  in  1`: 1 selects A−B. Sampled only on the first limb of a packet.
- `in_last  in  1`: this limb is the most-significant limb of the packet.
- `out_valid  out  1`: a result limb is held.
- `out_ready  in  1`: the downstream stage takes the result limb.
- `out_sum  out  32`: result limb.
- `out_idx  out  IDX_W`: limb position within the packet (0 = least significant).
- `out_last  out  1`: copy of `in_last` for this limb.
- `out_cout  out  1`: carry out of this limb. On the last limb it is the final carry; for subtract, 1 means no borrow.
- `out_ovf  out  1`: signed overflow. Valid only when `out_last`=1; 0 otherwise.

## Operation
- States:
  - `FIRST`: next accepted limb starts a packet.
  - `MID`: inside a packet.
- Transitions on an accepted limb (`in_valid && in_ready`):
  - `FIRST`→`MID` if `in_last`=0.
  - `MID`→`FIRST` if `in_last`=1.
  - Otherwise the state holds.
- Sub mode: on a `FIRST` acceptance, `sub_q` ← `in_sub`. A `FIRST` acceptance uses `in_sub` directly; `MID` acceptances use `sub_q`.
- Adder inputs:
  - a = `in_a`.
  - b = `in_b` XOR {32{sub}}.
  - cin = (state==`FIRST`) ? sub : `carry_q`.
- On acceptance:
  - `carry_q` ← `in_last` ? 0 : adder cout.
  - The output register loads sum, cout, `in_last`, and the index.
- Index: 0 for a `FIRST` acceptance; otherwise the previous index + 1, saturating at 2^IDX_W−1.
- Overflow: `out_ovf` = `in_last` & (a[31]==b'[31]) & (sum[31]!=a[31]), where b' is the post-XOR operand.
- Width rule: all arithmetic is modulo 2^32 per limb. No limb is ever dropped or duplicated.

## Timing
- Latency is 1 cycle. A limb accepted at edge N is visible on `out_*` with `out_valid`=1 after edge N.
- `in_ready` = !`out_valid` || `out_ready`. This is combinational, so full throughput is one limb per cycle.
- Simultaneous cases:
  - Output full, `out_ready`=1 and `in_valid`=1 in the same cycle: the old result is consumed and the new limb loads in the same edge.
  - Output full, `out_ready`=0: `in_ready`=0, and all `out_*` and `carry_q` hold stable.
- `out_valid` ← 0 when `out_ready`=1 and no new limb is accepted.
- Reset values: `out_valid`=0, `out_sum`=0, `out_idx`=0, `out_last`=0, `out_cout`=0, `out_ovf`=0, state=`FIRST`, `carry_q`=0, `sub_q`=0.
- Reset mid-packet: the partial packet is abandoned and no stale carry survives. The next accepted limb is treated as `FIRST`.
- `in_a`, `in_b`, `in_sub` and `in_last` are ignored when no transfer occurs.

## Structure
- Shared package `rca_pkg`:
  - `WORD_W`=32.
  - State enum `mp_state_t` {`FIRST`, `MID`}.
- Sub-module: one instance of `RCA_32` provides the limb adder, with ports `a`, `b`, `cin`, `sum`, `cout`. No other arithmetic is in this block.

## Test plan
- Single limb, A=0000ffff, B=000f0001, sub=0, last=1 → `out_sum`=00100000, `out_cout`=0, `out_ovf`=0, `out_idx`=0, one cycle later.
- Two limbs: {A=ffffffff, B=00000001} then {A=0, B=0, last=1} → `out_sum`=00000000 with cout=1, then 00000001 with cout=0, idx 0 then 1.
- Subtract, single limb:
  - A=5, B=3, sub=1 → sum 00000002, cout=1.
  - A=3, B=5 → sum fffffffe, cout=0.
- Signed overflow: A=7fffffff, B=00000001, last=1 → sum 80000000, `out_ovf`=1.
- Backpressure: hold `out_ready`=0 for 2 cycles with `in_valid`=1 → `in_ready`=0 and `out_*` stable. Release → every limb is delivered exactly once, in order.
- Reset mid-packet:
  - Send {A=ffffffff, B=1, last=0}, then assert `rst`.
  - Then send {A=1, B=1, last=1} → sum 00000002, idx 0, with no stale carry.

Source files
------------

// File: rtl/rca_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rca_pkg
//  Description : Shared word width and sequencer state type for the
//                multi-precision adder around RCA_32.
//  Revision    : 1.0 - initial release
// ============================================================================
package rca_pkg;

    localparam int WORD_W = 32;

    typedef enum logic [0:0] {
        FIRST = 1'b0,
        MID   = 1'b1
    } mp_state_t;

endpackage : rca_pkg
`default_nettype wire

// File: rtl/mp_add_seq_rca.sv
`default_nettype none
// ============================================================================
//  Module      : RCA_32
//  Description : 32-bit ripple-carry adder, one full adder per bit.
//  Revision    : 1.0 - initial release
// ============================================================================
module RCA_32
    import rca_pkg::*;
(
    input  logic [WORD_W-1:0] a,
    input  logic [WORD_W-1:0] b,
    input  logic              cin,
    output logic [WORD_W-1:0] sum,
    output logic              cout
);

    logic [WORD_W:0] w_c;

    assign w_c[0] = cin;

    // Carry ripples from bit 0 upward through one full adder per bit.
    generate
        for (genvar i = 0; i < WORD_W; i++) begin : g_bit
            assign sum[i]   = a[i] ^ b[i] ^ w_c[i];
            assign w_c[i+1] = (a[i] & b[i]) | (w_c[i] & (a[i] ^ b[i]));
        end
    endgenerate

    assign cout = w_c[WORD_W];

endmodule : RCA_32
`default_nettype wire

// File: rtl/mp_add_seq.sv
`default_nettype none
// ============================================================================
//  Module      : mp_add_seq
//  Description : Multi-precision add/subtract sequencer. Takes one 32-bit
//                limb per transfer (LS limb first), chains the carry between
//                limbs and streams results through a one-entry output reg.
//  Revision    : 1.0 - initial release
// ============================================================================
module mp_add_seq
    import rca_pkg::*;
#(
    parameter int IDX_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] in_a,
    input  logic [WORD_W-1:0] in_b,
    input  logic              in_sub,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WORD_W-1:0] out_sum,
    output logic [IDX_W-1:0]  out_idx,
    output logic              out_last,
    output logic              out_cout,
    output logic              out_ovf
);

    localparam logic [IDX_W-1:0] IDX_MAX = '1;

    mp_state_t         state_q, state_d;
    logic              carry_q, carry_d;
    logic              sub_q, sub_d;
    logic              out_valid_q, out_valid_d;
    logic [WORD_W-1:0] out_sum_q, out_sum_d;
    logic [IDX_W-1:0]  out_idx_q, out_idx_d;
    logic              out_last_q, out_last_d;
    logic              out_cout_q, out_cout_d;
    logic              out_ovf_q, out_ovf_d;

    logic              w_accept;
    logic              w_first;
    logic              w_sub;
    logic [WORD_W-1:0] w_b;
    logic              w_cin;
    logic [WORD_W-1:0] w_sum;
    logic              w_cout;

    // The output slot can take a new limb when empty or being drained now.
    assign in_ready = !out_valid_q || out_ready;
    assign w_accept = in_valid && in_ready;
    assign w_first  = (state_q == FIRST);

    // Subtraction is two's complement: invert B and inject 1 on the LS limb.
    assign w_sub = w_first ? in_sub : sub_q;
    assign w_b   = in_b ^ {WORD_W{w_sub}};
    assign w_cin = w_first ? w_sub : carry_q;

    RCA_32 u_rca (
        .a    (in_a),
        .b    (w_b),
        .cin  (w_cin),
        .sum  (w_sum),
        .cout (w_cout)
    );

    // Next-state: everything holds unless a limb is accepted; the valid
    // flag alone drops when the held result is taken with nothing behind it.
    always_comb begin
        state_d     = state_q;
        carry_d     = carry_q;
        sub_d       = sub_q;
        out_valid_d = out_valid_q;
        out_sum_d   = out_sum_q;
        out_idx_d   = out_idx_q;
        out_last_d  = out_last_q;
        out_cout_d  = out_cout_q;
        out_ovf_d   = out_ovf_q;

        if (w_accept) begin
            state_d     = in_last ? FIRST : MID;
            if (w_first) begin
                sub_d = in_sub;
            end
            carry_d     = in_last ? 1'b0 : w_cout;
            out_valid_d = 1'b1;
            out_sum_d   = w_sum;
            out_last_d  = in_last;
            out_cout_d  = w_cout;
            out_ovf_d   = in_last && (in_a[WORD_W-1] == w_b[WORD_W-1])
                                  && (w_sum[WORD_W-1] != in_a[WORD_W-1]);
            if (w_first) begin
                out_idx_d = '0;
            end else if (out_idx_q == IDX_MAX) begin
                out_idx_d = IDX_MAX;
            end else begin
                out_idx_d = out_idx_q + 1'b1;
            end
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // State, carry chain and output register; reset abandons any packet.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= FIRST;
            carry_q     <= 1'b0;
            sub_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_sum_q   <= '0;
            out_idx_q   <= '0;
            out_last_q  <= 1'b0;
            out_cout_q  <= 1'b0;
            out_ovf_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            carry_q     <= carry_d;
            sub_q       <= sub_d;
            out_valid_q <= out_valid_d;
            out_sum_q   <= out_sum_d;
            out_idx_q   <= out_idx_d;
            out_last_q  <= out_last_d;
            out_cout_q  <= out_cout_d;
            out_ovf_q   <= out_ovf_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_sum   = out_sum_q;
    assign out_idx   = out_idx_q;
    assign out_last  = out_last_q;
    assign out_cout  = out_cout_q;
    assign out_ovf   = out_ovf_q;

endmodule : mp_add_seq
`default_nettype wire

// File: tb/tb_mp_add_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mp_add_seq
//  Description : Self-checking bench for mp_add_seq with a queue-based
//                arithmetic reference model and directed literal cases.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mp_add_seq;

    localparam int IDX_W = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [31:0]       in_a = '0;
    logic [31:0]       in_b = '0;
    logic              in_sub = 1'b0;
    logic              in_last = 1'b0;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic [31:0]       out_sum;
    logic [IDX_W-1:0]  out_idx;
    logic              out_last;
    logic              out_cout;
    logic              out_ovf;

    int total = 0;
    int bad   = 0;

    mp_add_seq #(.IDX_W(IDX_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_sub    (in_sub),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_idx   (out_idx),
        .out_last  (out_last),
        .out_cout  (out_cout),
        .out_ovf   (out_ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [31:0]      sum;
        logic [IDX_W-1:0] idx;
        logic             last;
        logic             cout;
        logic             ovf;
    } exp_t;

    exp_t        q[$];
    bit          m_first = 1'b1;
    bit          m_carry = 1'b0;
    bit          m_sub   = 1'b0;
    int          m_idx   = 0;

    function automatic exp_t model_limb(input logic [31:0] a, input logic [31:0] b,
                                        input bit sub_e, input bit cin, input bit last, input int idx);
        exp_t           e;
        logic [32:0]    wide;
        longint         sa, sb, ss;
        logic [31:0]    bx;
        bx   = sub_e ? ~b : b;
        wide = {1'b0, a} + {1'b0, bx} + {32'd0, cin};
        sa   = longint'($signed(a));
        sb   = longint'($signed(bx));
        ss   = sa + sb + longint'(cin);
        e.sum  = wide[31:0];
        e.cout = wide[32];
        e.last = last;
        e.idx  = IDX_W'(idx);
        e.ovf  = last && (ss > 64'sd2147483647 || ss < -64'sd2147483648);
        return e;
    endfunction

    // One compare process: checks the DUT against the model on every cycle.
    always @(negedge clk) begin
        if (rst) begin
            q.delete();
            m_first = 1'b1;
            m_carry = 1'b0;
            m_sub   = 1'b0;
            m_idx   = 0;
            check("rst_out_valid", 32'(out_valid), 32'd0);
            check("rst_out_sum",   out_sum, 32'd0);
            check("rst_out_idx",   32'(out_idx), 32'd0);
            check("rst_out_flags", {29'd0, out_last, out_cout, out_ovf}, 32'd0);
        end else begin
            check("in_ready", 32'(in_ready), 32'(!out_valid || out_ready));
            check("out_valid", 32'(out_valid), 32'(q.size() != 0));
            if (out_valid && q.size() != 0) begin
                check("out_sum",  out_sum, q[0].sum);
                check("out_idx",  32'(out_idx), 32'(q[0].idx));
                check("out_last", 32'(out_last), 32'(q[0].last));
                check("out_cout", 32'(out_cout), 32'(q[0].cout));
                check("out_ovf",  32'(out_ovf), 32'(q[0].ovf));
            end
            if (out_valid && out_ready && q.size() != 0) begin
                void'(q.pop_front());
            end
            if (in_valid && in_ready) begin
                bit   sub_e;
                bit   cin;
                int   idx;
                sub_e = m_first ? in_sub : m_sub;
                cin   = m_first ? sub_e : m_carry;
                idx   = m_first ? 0 : ((m_idx >= (1 << IDX_W) - 1) ? (1 << IDX_W) - 1 : m_idx + 1);
                q.push_back(model_limb(in_a, in_b, sub_e, cin, in_last, idx));
                m_carry = in_last ? 1'b0 : q[q.size()-1].cout;
                m_sub   = sub_e;
                m_first = in_last;
                m_idx   = idx;
            end
        end
    end

    // Present a limb and wait (bounded) until it has been taken.
    task automatic drive(input logic [31:0] a, input logic [31:0] b, input bit sub, input bit last);
        int n;
        in_a = a; in_b = b; in_sub = sub; in_last = last; in_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            n++;
            @(negedge clk);
        end
        if (n >= 50) begin
            total++; bad++;
            $display("FAIL drive_timeout: in_ready stuck 0 for %0d cycles", n);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'hffffffff;
            1:       return 32'h00000000;
            2:       return 32'h7fffffff;
            3:       return 32'h80000000;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #2 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        out_ready = 1'b1;

        // Single limb add.
        drive(32'h0000ffff, 32'h000f0001, 1'b0, 1'b1);
        check("single_sum", out_sum, 32'h00100000);
        check("single_flags", {out_cout, out_ovf, out_valid}, 32'b001);
        check("single_idx", 32'(out_idx), 32'd0);

        // Two-limb carry propagation.
        drive(32'hffffffff, 32'h00000001, 1'b0, 1'b0);
        check("two_l0_sum", out_sum, 32'h0);
        check("two_l0_cout_idx", {out_cout, 8'(out_idx)}, {1'b1, 8'd0});
        drive(32'h0, 32'h0, 1'b0, 1'b1);
        check("two_l1_sum", out_sum, 32'h1);
        check("two_l1_cout_idx", {out_cout, 8'(out_idx)}, {1'b0, 8'd1});

        // Subtract, with and without borrow.
        drive(32'd5, 32'd3, 1'b1, 1'b1);
        check("sub_5_3", {out_cout, out_sum}, {1'b1, 32'h00000002});
        drive(32'd3, 32'd5, 1'b1, 1'b1);
        check("sub_3_5", {out_cout, out_sum}, {1'b0, 32'hfffffffe});

        // Signed overflow.
        drive(32'h7fffffff, 32'h00000001, 1'b0, 1'b1);
        check("ovf_sum", out_sum, 32'h80000000);
        check("ovf_flag", 32'(out_ovf), 32'd1);

        // Backpressure: output held, next limb stalls.
        @(posedge clk); #1;
        out_ready = 1'b0;
        drive(32'd1, 32'd2, 1'b0, 1'b0);
        in_a = 32'd3; in_b = 32'd4; in_last = 1'b1; in_valid = 1'b1;
        repeat (2) begin
            @(negedge clk);
            check("bp_in_ready", 32'(in_ready), 32'd0);
            check("bp_hold_sum", out_sum, 32'd3);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("bp_second_sum", out_sum, 32'd7);
        check("bp_second_idx", 32'(out_idx), 32'd1);

        // Reset in the middle of a packet.
        drive(32'hffffffff, 32'h1, 1'b0, 1'b0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        drive(32'h1, 32'h1, 1'b0, 1'b1);
        check("rst_mid_sum", out_sum, 32'h2);
        check("rst_mid_idx_cout", {out_cout, 8'(out_idx)}, 9'd0);

        // Index saturation on a long packet.
        for (int i = 0; i < 260; i++) begin
            drive($urandom, $urandom, 1'b0, i == 259);
        end
        check("idx_saturate", 32'(out_idx), 32'd255);

        // Randomized traffic with random backpressure.
        for (int i = 0; i < 1500; i++) begin
            @(posedge clk); #1;
            in_valid  = ($urandom_range(0, 3) != 0);
            in_a      = pick();
            in_b      = pick();
            in_sub    = $urandom_range(0, 1);
            in_last   = ($urandom_range(0, 3) == 0);
            out_ready = ($urandom_range(0, 3) != 0);
        end
        @(posedge clk); #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("drained", 32'(q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_mp_add_seq
`default_nettype wire
